// File: rtl/exp_pkg.sv
// Shared widths, fixed-point positions, FSM state type and the reciprocal
// table generator for the exp Taylor-series sequencer.
package exp_pkg;

    localparam int EXP_X_W    = 21;
    localparam int EXP_Y_W    = 27;
    localparam int RECIP_W    = 17;
    localparam int X_FRAC     = 17;
    localparam int Y_FRAC     = 23;
    localparam int RECIP_FRAC = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    // Iteration k of nterm multiplies by 1/(nterm+1-k), so Horner evaluation
    // walks from the highest-order term down to 1/1.
    function automatic logic [RECIP_W-1:0] recip_rom(input int k, input int nterm);
        int den;
        den = nterm + 1 - k;
        if (k < 1 || k > nterm) begin
            return '0;
        end
        return RECIP_W'((1 << RECIP_FRAC) / den);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  id
);

    always_comb begin
        int idx;
        logic found;
        logic [IDW-1:0] idx_b;
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        idx_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_b = IDW'(idx);
            if (!found && req[idx_b]) begin
                found      = 1'b1;
                gnt[idx_b] = 1'b1;
                id         = idx_b;
            end
        end
    end

endmodule

// File: rtl/exp_sched.sv
// Arbitrates NREQ requesters onto one shared exp unit and sequences its
// init/run/recip protocol, returning each result tagged with its requester id.
module exp_sched
    import exp_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NTERM = 15,
    parameter int Y_LAT = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*EXP_X_W-1:0]   x_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      exp_init,
    output logic                      exp_run,
    output logic [EXP_X_W-1:0]        exp_x,
    output logic [RECIP_W-1:0]        exp_recip,
    input  logic [EXP_Y_W-1:0]        exp_y,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [EXP_Y_W-1:0]        rsp_y,
    output logic                      busy
);

    localparam int KW = $clog2(NTERM + 1);
    localparam int DW = $clog2(Y_LAT + 1);
    localparam logic [KW-1:0]  K_FIRST = KW'(1);
    localparam logic [KW-1:0]  K_LAST  = KW'(NTERM);
    localparam logic [DW-1:0]  D_FIRST = DW'(1);
    localparam logic [DW-1:0]  D_LAST  = DW'(Y_LAT);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

    sched_state_t         state;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       cur_id;
    logic [IDW-1:0]       arb_id;
    logic [NREQ-1:0]      arb_gnt;
    logic [KW-1:0]        k;
    logic [DW-1:0]        d;
    logic [RECIP_W-1:0]   recip_tbl [NTERM+1];

    for (genvar g = 0; g <= NTERM; g++) begin : g_recip
        assign recip_tbl[g] = recip_rom(g, NTERM);
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .id  (arb_id)
    );

    // k holds the iteration currently on exp_run; its recip is loaded one
    // cycle early so both reach the unit together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            k         <= '0;
            d         <= '0;
            gnt       <= '0;
            exp_init  <= 1'b0;
            exp_run   <= 1'b0;
            exp_x     <= '0;
            exp_recip <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            busy      <= 1'b0;
        end else begin
            gnt       <= '0;
            exp_init  <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        cur_id   <= arb_id;
                        exp_x    <= x_in[arb_id*EXP_X_W +: EXP_X_W];
                        gnt      <= arb_gnt;
                        exp_init <= 1'b1;
                        busy     <= 1'b1;
                        state    <= INIT;
                    end
                end
                INIT: begin
                    rr_ptr    <= (cur_id == ID_LAST) ? '0 : cur_id + 1'b1;
                    k         <= K_FIRST;
                    exp_run   <= 1'b1;
                    exp_recip <= recip_tbl[K_FIRST];
                    state     <= RUN;
                end
                RUN: begin
                    if (k == K_LAST) begin
                        exp_run   <= 1'b0;
                        exp_recip <= '0;
                        d         <= D_FIRST;
                        state     <= DRAIN;
                    end else begin
                        k         <= k + 1'b1;
                        exp_recip <= recip_tbl[k + 1'b1];
                    end
                end
                DRAIN: begin
                    // exp_y only settles in the final drain cycle.
                    if (d == D_LAST) begin
                        rsp_y     <= exp_y;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        d <= d + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
